// File: rtl/rect_pkg.sv
// Shared constants and corner-packing helpers for the rectilinearizer datapath.
package rect_pkg;

    localparam int COORD_W  = 10;
    // Upper bound on a packed corner set, used to size the default-corner builder.
    localparam int MAX_FLAT = 1024;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_ARMED   = 1'b1
    } slot_state_e;

    // Bit offset of the x field of corner idx (x sits in the low half).
    function automatic int x_lsb(input int idx, input int cw);
        return idx * 2 * cw;
    endfunction

    // Bit offset of the y field of corner idx (y sits in the high half).
    function automatic int y_lsb(input int idx, input int cw);
        return idx * 2 * cw + cw;
    endfunction

    // Full-frame quadrilateral: (0,0), (W-1,0), (W-1,H-1), (0,H-1); extra corners are 0.
    function automatic logic [MAX_FLAT-1:0] default_corners(input int cw, input int n,
                                                            input int img_w, input int img_h);
        logic [MAX_FLAT-1:0] f;
        int x;
        int y;
        f = '0;
        for (int i = 0; i < n; i++) begin
            x = (i == 1 || i == 2) ? img_w - 1 : 0;
            y = (i == 2 || i == 3) ? img_h - 1 : 0;
            for (int b = 0; b < cw; b++) begin
                f[x_lsb(i, cw) + b] = x[b];
                f[y_lsb(i, cw) + b] = y[b];
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/corner_bank_slot.sv
// One corner set: staging array, active array, written-mask and COLLECT/ARMED state.
module corner_set_slot #(
    parameter  int COORD_W     = rect_pkg::COORD_W,
    parameter  int NUM_CORNERS = 4,
    parameter  int IMG_W       = 640,
    parameter  int IMG_H       = 480,
    localparam int IDX_W       = (NUM_CORNERS > 1) ? $clog2(NUM_CORNERS) : 1,
    localparam int FLAT_W      = NUM_CORNERS * 2 * COORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic              commit,
    output logic [FLAT_W-1:0] active_flat,
    output logic              armed,
    output logic              reject
);
    import rect_pkg::*;

    localparam logic [MAX_FLAT-1:0]    DEF_ALL  = default_corners(COORD_W, NUM_CORNERS, IMG_W, IMG_H);
    localparam logic [FLAT_W-1:0]      DEF_FLAT = DEF_ALL[FLAT_W-1:0];
    localparam logic [NUM_CORNERS-1:0] FULL     = '1;

    slot_state_e              state_d, state_q;
    logic [NUM_CORNERS-1:0]   mask_d, mask_q;
    logic [FLAT_W-1:0]        stage_d, stage_q;
    logic [FLAT_W-1:0]        active_d, active_q;

    // Staging writes, commit evaluation and frame-boundary transfer for this set.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        stage_d  = stage_q;
        active_d = active_q;
        reject   = 1'b0;
        if (state_q == ST_ARMED) begin
            // Staging is locked while waiting for the frame boundary.
            if (wr_en || commit) begin
                reject = 1'b1;
            end
            if (frame_start) begin
                active_d = stage_q;
                mask_d   = '0;
                state_d  = ST_COLLECT;
            end
        end else begin
            if (wr_en) begin
                stage_d[x_lsb(int'(wr_idx), COORD_W) +: COORD_W] = wr_x;
                stage_d[y_lsb(int'(wr_idx), COORD_W) +: COORD_W] = wr_y;
                mask_d[wr_idx] = 1'b1;
            end
            // A commit sees a write issued in the same cycle; a concurrent
            // frame_start does not transfer a set that only arms now.
            if (commit) begin
                if (mask_d == FULL) begin
                    state_d = ST_ARMED;
                end else begin
                    reject = 1'b1;
                end
            end
        end
    end

    // Set state registers; reset restores the full-frame quadrilateral.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_COLLECT;
            mask_q   <= '0;
            stage_q  <= DEF_FLAT;
            active_q <= DEF_FLAT;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            stage_q  <= stage_d;
            active_q <= active_d;
        end
    end

    // Post-transfer view so the top-level output register loads fresh contents
    // on the same edge as the transfer; equals active_q outside that edge.
    assign active_flat = active_d;
    assign armed       = (state_q == ST_ARMED);

endmodule

// File: rtl/corner_bank.sv
// Frame-synchronous double-buffered bank of quadrilateral corner sets.
module corner_bank #(
    parameter  int COORD_W     = rect_pkg::COORD_W,
    parameter  int NUM_CORNERS = 4,
    parameter  int NUM_SETS    = 2,
    parameter  int IMG_W       = 640,
    parameter  int IMG_H       = 480,
    localparam int SET_W       = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    localparam int IDX_W       = (NUM_CORNERS > 1) ? $clog2(NUM_CORNERS) : 1,
    localparam int FLAT_W      = NUM_CORNERS * 2 * COORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               wr_en,
    input  logic [SET_W-1:0]   wr_set,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic               commit,
    input  logic [SET_W-1:0]   sel,
    output logic [FLAT_W-1:0]  corners_out,
    output logic [SET_W-1:0]   out_set,
    output logic [NUM_SETS-1:0] armed,
    output logic               swap_done,
    output logic               err
);
    import rect_pkg::*;

    localparam logic [MAX_FLAT-1:0] DEF_ALL  = default_corners(COORD_W, NUM_CORNERS, IMG_W, IMG_H);
    localparam logic [FLAT_W-1:0]   DEF_FLAT = DEF_ALL[FLAT_W-1:0];

    logic                set_ok, idx_ok, sel_ok, range_err;
    logic [NUM_SETS-1:0] slot_wr, slot_commit, slot_armed, slot_reject;
    logic [FLAT_W-1:0]   slot_next [NUM_SETS];

    logic [SET_W-1:0]    out_set_d, out_set_q;
    logic [FLAT_W-1:0]   corners_d, corners_q;
    logic                swap_d, swap_q;
    logic                err_d, err_q;

    // Route write/commit to the addressed set; out-of-range addresses are rejected.
    always_comb begin
        set_ok    = 32'(wr_set) < NUM_SETS;
        idx_ok    = 32'(wr_idx) < NUM_CORNERS;
        sel_ok    = 32'(sel) < NUM_SETS;
        slot_wr     = '0;
        slot_commit = '0;
        for (int s = 0; s < NUM_SETS; s++) begin
            slot_wr[s]     = wr_en && set_ok && idx_ok && (32'(wr_set) == s);
            slot_commit[s] = commit && set_ok && (32'(wr_set) == s);
        end
        range_err = (wr_en && !(set_ok && idx_ok)) ||
                    (commit && !set_ok) ||
                    (frame_start && !sel_ok);
    end

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_slot
        corner_set_slot #(
            .COORD_W    (COORD_W),
            .NUM_CORNERS(NUM_CORNERS),
            .IMG_W      (IMG_W),
            .IMG_H      (IMG_H)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .frame_start(frame_start),
            .wr_en      (slot_wr[s]),
            .wr_idx     (wr_idx),
            .wr_x       (wr_x),
            .wr_y       (wr_y),
            .commit     (slot_commit[s]),
            .active_flat(slot_next[s]),
            .armed      (slot_armed[s]),
            .reject     (slot_reject[s])
        );
    end

    // Latch sel and reload the output only at a frame boundary.
    always_comb begin
        out_set_d = out_set_q;
        corners_d = corners_q;
        if (frame_start) begin
            if (sel_ok) begin
                out_set_d = sel;
            end
            corners_d = slot_next[out_set_d];
        end
        swap_d = frame_start;
        err_d  = range_err || (|slot_reject);
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_set_q <= '0;
            corners_q <= DEF_FLAT;
            swap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            out_set_q <= out_set_d;
            corners_q <= corners_d;
            swap_q    <= swap_d;
            err_q     <= err_d;
        end
    end

    assign corners_out = corners_q;
    assign out_set     = out_set_q;
    assign armed       = slot_armed;
    assign swap_done   = swap_q;
    assign err         = err_q;

endmodule

// File: tb/tb_corner_bank.sv
// Bench for corner_bank: directed table, hand sequences and randomized traffic vs a model.
module tb_corner_bank;

    localparam int CW = 10;
    localparam int NC = 4;
    localparam int NS = 2;
    localparam int FW = NC * 2 * CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          wr_en;
    logic [0:0]    wr_set;
    logic [1:0]    wr_idx;
    logic [CW-1:0] wr_x;
    logic [CW-1:0] wr_y;
    logic          commit;
    logic [0:0]    sel;
    logic [FW-1:0] corners_out;
    logic [0:0]    out_set;
    logic [NS-1:0] armed;
    logic          swap_done;
    logic          err;

    always #5 clk = ~clk;

    corner_bank #(
        .COORD_W(CW), .NUM_CORNERS(NC), .NUM_SETS(NS), .IMG_W(640), .IMG_H(480)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .wr_en(wr_en),
        .wr_set(wr_set), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .commit(commit), .sel(sel), .corners_out(corners_out), .out_set(out_set),
        .armed(armed), .swap_done(swap_done), .err(err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model (arrays of coordinates) ----------------
    int            sx [NS][NC];
    int            sy [NS][NC];
    int            ax [NS][NC];
    int            ay [NS][NC];
    int            msk [NS];
    bit            arm [NS];
    int            m_oset;
    logic [FW-1:0] m_corners;
    bit            m_swap;
    bit            m_err;

    function automatic int dflt_x(input int c);
        return (c == 1 || c == 2) ? 639 : 0;
    endfunction

    function automatic int dflt_y(input int c);
        return (c == 2 || c == 3) ? 479 : 0;
    endfunction

    function automatic logic [FW-1:0] pack_active(input int s);
        logic [FW-1:0] v;
        v = '0;
        for (int c = 0; c < NC; c++) begin
            v[c*2*CW +: CW]      = CW'(ax[s][c]);
            v[c*2*CW + CW +: CW] = CW'(ay[s][c]);
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int c = 0; c < NC; c++) begin
                sx[s][c] = dflt_x(c); sy[s][c] = dflt_y(c);
                ax[s][c] = dflt_x(c); ay[s][c] = dflt_y(c);
            end
            msk[s] = 0;
            arm[s] = 0;
        end
        m_oset    = 0;
        m_corners = pack_active(0);
        m_swap    = 0;
        m_err     = 0;
    endtask

    // Apply one clock edge's worth of spec rules to the model.
    task automatic model_step();
        bit hw;
        bit hc;
        m_err  = 0;
        m_swap = frame_start;
        for (int s = 0; s < NS; s++) begin
            hw = wr_en && (int'(wr_set) == s);
            hc = commit && (int'(wr_set) == s);
            if (arm[s]) begin
                if (hw || hc) m_err = 1;
                if (frame_start) begin
                    for (int c = 0; c < NC; c++) begin
                        ax[s][c] = sx[s][c];
                        ay[s][c] = sy[s][c];
                    end
                    msk[s] = 0;
                    arm[s] = 0;
                end
            end else begin
                if (hw) begin
                    sx[s][int'(wr_idx)] = int'(wr_x);
                    sy[s][int'(wr_idx)] = int'(wr_y);
                    msk[s] = msk[s] | (1 << int'(wr_idx));
                end
                if (hc) begin
                    if (msk[s] == (1 << NC) - 1) arm[s] = 1;
                    else m_err = 1;
                end
            end
        end
        if (frame_start) begin
            m_oset    = int'(sel);
            m_corners = pack_active(m_oset);
        end
    endtask

    function automatic int model_armed();
        int a;
        a = 0;
        for (int s = 0; s < NS; s++) if (arm[s]) a = a | (1 << s);
        return a;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk_i(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_v(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk_v({tag, ".corners"}, corners_out, m_corners);
        chk_i({tag, ".out_set"}, int'(out_set), m_oset);
        chk_i({tag, ".armed"}, int'(armed), model_armed());
        chk_i({tag, ".swap_done"}, int'(swap_done), int'(m_swap));
        chk_i({tag, ".err"}, int'(err), int'(m_err));
    endtask

    task automatic drive(input bit fs, input bit we, input int ws, input int wi,
                         input int wx, input int wy, input bit cm, input int sv);
        frame_start = fs;
        wr_en       = we;
        wr_set      = 1'(ws);
        wr_idx      = 2'(wi);
        wr_x        = CW'(wx);
        wr_y        = CW'(wy);
        commit      = cm;
        sel         = 1'(sv);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int fs, we, ws, wi, wx, wy, cm, sv;
        int ea, ee, es, eo;
    } vec_t;

    vec_t          tbl[$];
    logic [FW-1:0] defv;

    initial begin
        defv = {10'd479, 10'd0, 10'd479, 10'd639, 10'd0, 10'd639, 10'd0, 10'd0};

        //            fs we ws wi  wx   wy  cm sel | armed err swap oset
        tbl.push_back('{1, 0, 0, 0,   0,   0, 0, 0,   0, 0, 1, 0}); // defaults out
        tbl.push_back('{0, 0, 0, 0,   0,   0, 0, 0,   0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 100,  10, 0, 0,   0, 0, 0, 0}); // set1 corners
        tbl.push_back('{0, 1, 1, 1, 500,  20, 0, 0,   0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 2, 510, 400, 0, 0,   0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 3,  90, 410, 0, 0,   0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0,   0,   0, 1, 0,   2, 0, 0, 0}); // commit set1
        tbl.push_back('{0, 0, 0, 0,   0,   0, 0, 0,   2, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0,   0,   0, 0, 1,   0, 0, 1, 1}); // swap to set1
        tbl.push_back('{0, 1, 0, 0,  11,  21, 0, 0,   0, 0, 0, 1}); // set0, 3 corners
        tbl.push_back('{0, 1, 0, 1,  12,  22, 0, 0,   0, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 2,  13,  23, 0, 0,   0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   0, 1, 0, 1}); // incomplete commit
        tbl.push_back('{0, 0, 0, 0,   0,   0, 0, 0,   0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 0,   0,   0, 0, 1,   0, 0, 1, 1}); // nothing transferred
        tbl.push_back('{0, 1, 0, 3,  14,  24, 0, 0,   0, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0,   0,   0, 1, 0,   1, 0, 0, 1}); // arm set0
        tbl.push_back('{0, 1, 0, 0,   1,   1, 0, 0,   1, 1, 0, 1}); // write to armed
        tbl.push_back('{1, 0, 0, 0,   0,   0, 0, 0,   0, 0, 1, 0}); // pre-arm values out
        tbl.push_back('{0, 1, 1, 0, 200, 201, 0, 0,   0, 0, 0, 0}); // new set1
        tbl.push_back('{0, 1, 1, 1, 202, 203, 0, 0,   0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 2, 204, 205, 0, 0,   0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 3, 206, 207, 0, 0,   0, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 0,   0,   0, 1, 1,   2, 0, 1, 1}); // commit + frame_start
        tbl.push_back('{0, 0, 0, 0,   0,   0, 0, 0,   2, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 0,   0,   0, 0, 1,   0, 0, 1, 1}); // deferred transfer
        tbl.push_back('{0, 1, 0, 0, 300, 301, 0, 0,   0, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 1, 302, 303, 0, 0,   0, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 2, 304, 305, 0, 0,   0, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 3, 306, 307, 1, 0,   1, 0, 0, 1}); // write + commit same cycle
        tbl.push_back('{1, 1, 1, 0,   7,   7, 0, 0,   0, 0, 1, 0}); // write during frame_start

        // Reset state
        idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_v("reset.corners", corners_out, defv);
        chk_i("reset.out_set", int'(out_set), 0);
        chk_i("reset.armed", int'(armed), 0);
        chk_i("reset.swap_done", int'(swap_done), 0);
        chk_i("reset.err", int'(err), 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].fs != 0, tbl[i].we != 0, tbl[i].ws, tbl[i].wi,
                  tbl[i].wx, tbl[i].wy, tbl[i].cm != 0, tbl[i].sv);
            cycle();
            chk_i($sformatf("row%0d.armed", i), int'(armed), tbl[i].ea);
            chk_i($sformatf("row%0d.err", i), int'(err), tbl[i].ee);
            chk_i($sformatf("row%0d.swap_done", i), int'(swap_done), tbl[i].es);
            chk_i($sformatf("row%0d.out_set", i), int'(out_set), tbl[i].eo);
            chk_v($sformatf("row%0d.corners", i), corners_out, m_corners);
            if (i == 0) chk_v("first_swap.defaults", corners_out, defv);
        end

        // Reset while set 1 is armed
        drive(1, 1, 1, 0, 11, 12, 0, 1);
        cycle();
        check_model("rst_seq.w0");
        for (int c = 1; c < NC; c++) begin
            drive(0, 1, 1, c, 40 + c, 50 + c, 0, 0);
            cycle();
        end
        drive(0, 0, 1, 0, 0, 0, 1, 0);
        cycle();
        chk_i("rst_seq.armed_before", int'(armed), 2);
        chk_i("rst_seq.out_set_before", int'(out_set), 1);
        idle();
        reset = 1'b1;
        #2;
        model_reset();
        chk_i("rst_seq.armed", int'(armed), 0);
        chk_i("rst_seq.out_set", int'(out_set), 0);
        chk_v("rst_seq.corners", corners_out, defv);
        chk_i("rst_seq.err", int'(err), 0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        chk_v("rst_seq.after_swap", corners_out, defv);
        check_model("rst_seq.after");

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                  $urandom_range(0, 4) == 0, int'($urandom_range(0, 1)));
            cycle();
            check_model($sformatf("rnd%0d", i));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
